// File: rtl/core_clk_pkg.sv
// ---------------------------------------------------------------------------
// core_clk_pkg : shared types and constants for the core clock controller.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package core_clk_pkg;

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    STEP     = 2'd3
  } state_t;

  localparam int DIV_MIN = 1;

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider : period counter with active divider and terminal detect.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_divider
  import core_clk_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             countEn,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] c_divMin   = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] c_divReset = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_divAct;
  logic [CNT_W-1:0] w_cntEff;
  logic [CNT_W-1:0] w_loadClamped;

  // A clear is seen in the entry cycle itself, so D=1 fires immediately.
  always_comb begin
    w_cntEff      = clear ? '0 : r_cnt;
    terminal      = countEn && (w_cntEff == (r_divAct - CNT_W'(1)));
    w_loadClamped = (loadVal == '0) ? c_divMin : loadVal;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_divAct <= c_divReset;
    end else begin
      if (!countEn || terminal) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cntEff + CNT_W'(1);
      end
      if (load) begin
        r_divAct <= w_loadClamped;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_clk_ctrl.sv
// ---------------------------------------------------------------------------
// core_clk_ctrl : run/halt/single-step controller producing the core clkEn.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module core_clk_ctrl
  import core_clk_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 1,
  parameter int START_RUN   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             runReq,
  input  logic             haltReq,
  input  logic             stepReq,
  input  logic [CNT_W-1:0] cfgDiv,
  input  logic             cfgValid,
  output logic             cfgReady,
  output logic             clkEn,
  output logic             halted,
  output logic [CNT_W-1:0] tickCnt
);

  localparam state_t c_resetState = (START_RUN != 0) ? RUN : HALT;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_halt;
  logic             w_step;
  logic             w_run;
  logic             w_entering;
  logic             w_countEn;
  logic             w_terminal;
  logic             w_load;
  logic             w_xfer;
  logic             w_nextPend;
  logic             r_pendValid;
  logic [CNT_W-1:0] r_pendDiv;
  logic             r_cfgReady;
  logic             r_clkEn;
  logic [CNT_W-1:0] r_tickCnt;

  always_comb begin
    w_halt     = haltReq;
    w_step     = stepReq & ~haltReq;
    w_run      = runReq & ~haltReq & ~stepReq;
    w_entering = (r_state == HALT) && (w_step || w_run);
    w_countEn  = (r_state != HALT) || w_entering;
    w_load     = r_pendValid && ((r_state == HALT) || w_terminal);
    w_xfer     = cfgValid && r_cfgReady;
    w_nextPend = w_load ? 1'b0 : (w_xfer ? 1'b1 : r_pendValid);
  end

  tick_divider #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_divider (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (w_entering),
    .countEn  (w_countEn),
    .load     (w_load),
    .loadVal  (r_pendDiv),
    .terminal (w_terminal)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      // A D=1 step completes in its entry cycle and never occupies STEP.
      HALT: begin
        if (w_step) begin
          w_nextState = w_terminal ? HALT : STEP;
        end else if (w_run) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_halt) begin
          w_nextState = STOPPING;
        end
      end
      STOPPING: begin
        if (w_run) begin
          w_nextState = RUN;
        end else if (w_terminal) begin
          w_nextState = HALT;
        end
      end
      STEP: begin
        if (w_terminal) begin
          w_nextState = HALT;
        end
      end
      default: w_nextState = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= c_resetState;
      r_pendValid <= 1'b0;
      r_pendDiv   <= '0;
      r_cfgReady  <= 1'b1;
      r_clkEn     <= 1'b0;
      r_tickCnt   <= '0;
    end else begin
      r_state     <= w_nextState;
      r_pendValid <= w_nextPend;
      r_cfgReady  <= ~w_nextPend;
      r_clkEn     <= w_terminal;
      if (w_xfer) begin
        r_pendDiv <= cfgDiv;
      end
      if (w_terminal) begin
        r_tickCnt <= r_tickCnt + CNT_W'(1);
      end
    end
  end

  assign cfgReady = r_cfgReady;
  assign clkEn    = r_clkEn;
  assign halted   = (r_state == HALT);
  assign tickCnt  = r_tickCnt;

endmodule

`default_nettype wire

// File: tb/tb_core_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_clk_ctrl : scoreboard bench for core_clk_ctrl, pulse-time model.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_core_clk_ctrl;

  localparam int CNT_W = 32;
  localparam int DEF   = 4;

  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_STEP = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             runReq = 1'b0;
  logic             haltReq = 1'b0;
  logic             stepReq = 1'b0;
  logic [CNT_W-1:0] cfgDiv = '0;
  logic             cfgValid = 1'b0;
  logic             cfgReady;
  logic             clkEn;
  logic             halted;
  logic [CNT_W-1:0] tickCnt;

  core_clk_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF),
    .START_RUN   (0)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .runReq   (runReq),
    .haltReq  (haltReq),
    .stepReq  (stepReq),
    .cfgDiv   (cfgDiv),
    .cfgValid (cfgValid),
    .cfgReady (cfgReady),
    .clkEn    (clkEn),
    .halted   (halted),
    .tickCnt  (tickCnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] tick;
    logic        halted;
  } pulse_t;

  pulse_t expq[$];
  pulse_t monP;

  // Reference model: mode plus the absolute cycle of the next enable pulse.
  int          mMode;
  int          mD;
  bit          mPend;
  int          mPendVal;
  int          mNext;
  logic [31:0] mTick;
  bit          mRdy;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mMode    = M_HALT;
    mD       = DEF;
    mPend    = 0;
    mPendVal = 0;
    mNext    = 0;
    mTick    = '0;
    mRdy     = 1;
    expq.delete();
  endtask

  task automatic model(input int n, input bit r, input bit h, input bit s,
                       input bit cv, input int cd);
    int     req;
    int     newMode;
    int     dNext;
    bit     term;
    bit     load;
    pulse_t p;
    req     = h ? 1 : (s ? 2 : (r ? 3 : 0));
    newMode = mMode;
    if (mMode == M_HALT && (req == 2 || req == 3)) begin
      newMode = (req == 2) ? M_STEP : M_RUN;
      mNext   = n + mD;
    end
    term  = (newMode != M_HALT) && (mNext == n + 1);
    load  = mPend && (mMode == M_HALT || term);
    dNext = load ? ((mPendVal == 0) ? 1 : mPendVal) : mD;
    case (mMode)
      M_RUN:   if (req == 1) newMode = M_STOP;
      M_STOP:  if (req == 3) newMode = M_RUN; else if (term) newMode = M_HALT;
      M_STEP:  if (term) newMode = M_HALT;
      default: if (newMode == M_STEP && term) newMode = M_HALT;
    endcase
    if (term) begin
      mTick    = mTick + 1;
      p.cyc    = n + 1;
      p.tick   = mTick;
      p.halted = (newMode == M_HALT);
      expq.push_back(p);
      if (newMode != M_HALT) mNext = n + 1 + dNext;
    end
    mD = dNext;
    if (load) mPend = 0;
    if (cv && mRdy) begin
      mPend    = 1;
      mPendVal = cd;
    end
    mRdy  = !mPend;
    mMode = newMode;
  endtask

  // Called at a falling edge; drives one cycle of stimulus.
  task automatic cycle_step(input bit r, input bit h, input bit s,
                            input bit cv, input int cd);
    if (mMode == M_HALT && mPend) begin
      r = 0;
      s = 0;
    end
    check("halted", halted, (mMode == M_HALT));
    check("cfgReady", cfgReady, mRdy);
    runReq   = r;
    haltReq  = h;
    stepReq  = s;
    cfgValid = cv;
    cfgDiv   = cd;
    model(cyc, r, h, s, cv, cd);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle_step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int hold);
    #1;
    rstn     = 1'b0;
    runReq   = 1'b0;
    haltReq  = 1'b0;
    stepReq  = 1'b0;
    cfgValid = 1'b0;
    model_reset();
    #1;
    check("rst_clkEn", clkEn, 0);
    check("rst_tickCnt", tickCnt, 0);
    check("rst_cfgReady", cfgReady, 1);
    check("rst_halted", halted, 1);
    repeat (hold) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: every emitted pulse must match the head of the expected queue.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse: got none expected pulse at cycle %0d", expq[0].cyc);
      void'(expq.pop_front());
    end
    if (clkEn) begin
      if (expq.size() == 0 || expq[0].cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got clkEn=1 at cycle %0d expected 0", cyc);
      end else begin
        monP = expq.pop_front();
        check("pulse_tickCnt", tickCnt, monP.tick);
        check("pulse_halted", halted, monP.halted);
      end
    end
  end

  initial begin
    int t0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Run from halt with D=4: pulses at t0+4, t0+8, t0+12.
    idle(5);
    t0 = cyc;
    cycle_step(1, 0, 0, 0, 0);
    idle(11);
    check("tick_three_periods", tickCnt, 3);
    check("clkEn_third_period", clkEn, 1);

    // Halt two cycles into a period.
    idle(2);
    cycle_step(0, 1, 0, 0, 0);
    idle(50);
    check("halted_after_stop", halted, 1);
    check("tick_after_stop", tickCnt, 4);

    // Single step with D=3; extra step requests during STEP are ignored.
    cycle_step(0, 0, 0, 1, 3);
    idle(3);
    cycle_step(0, 0, 1, 0, 0);
    cycle_step(0, 0, 1, 0, 0);
    cycle_step(0, 0, 1, 0, 0);
    idle(6);
    check("tick_after_step", tickCnt, 5);

    // Reconfigure mid-period in RUN; a held cfgValid stalls while pending.
    cycle_step(0, 0, 0, 1, 2);
    idle(3);
    cycle_step(1, 0, 0, 0, 0);
    idle(4);
    cycle_step(0, 0, 0, 1, 5);
    for (int i = 0; i < 8; i++) cycle_step(0, 0, 0, 1, 7);
    idle(20);

    // Divider 0 behaves as 1: clkEn constantly high.
    cycle_step(0, 0, 0, 1, 0);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      check("clkEn_div1", clkEn, 1);
      idle(1);
    end
    cycle_step(1, 1, 0, 0, 0);
    idle(5);
    check("halted_after_halt_run", halted, 1);

    // Reset asserted in STEP one cycle before terminal count.
    cycle_step(0, 0, 0, 1, 3);
    idle(3);
    cycle_step(0, 0, 1, 0, 0);
    do_reset(2);
    idle(10);
    check("tick_after_step_reset", tickCnt, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle_step(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0),
                 int'($urandom_range(0, 6)));
    end

    cycle_step(0, 1, 0, 0, 0);
    idle(30);
    check("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
